dual_port_ram_core: RTL and testbench
=====================================

DUAL_PORT_RAM_CORE -- requirements
Module: dual_port_ram_core

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word-address width of both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width of both ports.
REQ-003 SHALL have port clk  input  1  single clock for both ports and all state.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports a_en / b_en  input  1  port A / port B access enable.
REQ-006 SHALL have ports a_we / b_we  input  1  write strobe, valid only with matching en.
REQ-007 SHALL have ports a_addr / b_addr  input  ADDR_WIDTH  word address.
REQ-008 SHALL have ports a_wdata / b_wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have ports a_rdata / b_rdata  output  DATA_WIDTH  read data.
REQ-010 SHALL have port init_done  output  1  high once the power-up clear sweep has finished.
REQ-011 SHALL have port collision  output  1  one-cycle pulse on an A/B same-address write conflict.

Function
REQ-012 SHALL act as the memory-side responder, with 2**ADDR_WIDTH words of DATA_WIDTH bits.
REQ-013 SHALL implement an FSM with states CLEAR and READY; reset enters CLEAR with clear pointer 0.
REQ-014 In CLEAR, SHALL write 0 to mem[ptr] each cycle and increment ptr; after writing ptr = 2**ADDR_WIDTH-1, SHALL move to READY.
REQ-015 SHALL assert init_done in the first READY cycle, exactly 2**ADDR_WIDTH cycles after reset release, and hold it until reset.
REQ-016 In CLEAR, SHALL ignore all port requests (no write, rdata held at 0).
REQ-017 In READY, a write (en=1, we=1) SHALL update mem[addr] at the clock edge.
REQ-018 In READY, a read (en=1, we=0) SHALL present mem[addr] on rdata one cycle after the request.
REQ-019 A write cycle SHALL also return the old contents of mem[addr] on that port's rdata one cycle later (read-first).
REQ-020 When en=0, the port's rdata SHALL hold its previous value.
REQ-021 If A writes and B reads the same address in one cycle, B SHALL receive the old data.
REQ-022 If A and B both write the same address in one cycle, port A data SHALL be stored and collision SHALL pulse high one cycle later.
REQ-023 Writes to different addresses in one cycle SHALL both take effect, with no collision.

Reset
REQ-024 rst high SHALL immediately force a_rdata=0, b_rdata=0, init_done=0, collision=0, state CLEAR, ptr=0.
REQ-025 Reset asserted mid-sweep or in READY SHALL restart the full clear sweep on release.
REQ-026 Array contents SHALL NOT be reset directly; only the sweep clears them.

Configuration
REQ-027 Macro DUAL_PORT_RAM_OUT_REG_EN, when defined, SHALL add one output register stage per port: read latency 2; collision also delayed one extra cycle.
REQ-028 Without DUAL_PORT_RAM_OUT_REG_EN, read latency SHALL be 1 as in REQ-018.
REQ-029 The output register stage SHALL reset to 0 and hold when its port's previous-cycle en=0.

Structure
REQ-030 Package dual_port_ram_pkg SHALL hold the FSM state enum (CLEAR, READY) and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-031 The clear sequencer (FSM, ptr, init_done) SHALL be sub-module dual_port_ram_init_seq; the array and port logic remain in the core.

Verification
REQ-032 Reset, then count cycles to init_done with ADDR_WIDTH=4 -> init_done rises after 16 cycles; a read of every address then returns 0.
REQ-033 A writes 0xDEADBEEF to 0x10, then B reads 0x10 -> b_rdata=0xDEADBEEF one cycle later (two with DUAL_PORT_RAM_OUT_REG_EN).
REQ-034 A writes 0x11111111 to 0x20 while B writes 0x22222222 to 0x20 -> collision pulse one cycle; a later read returns 0x11111111.
REQ-035 mem[0x05]=0xA5A5A5A5; A writes 0x5A5A5A5A to 0x05 while B reads 0x05 -> b_rdata=0xA5A5A5A5, next B read returns 0x5A5A5A5A.
REQ-036 Assert rst at ptr=7 during CLEAR -> on release init_done stays 0 for a full 2**ADDR_WIDTH cycles and writes issued during CLEAR are lost.
REQ-037 Read 0x01 then drop a_en for 3 cycles -> a_rdata holds the 0x01 data throughout.

Source files
------------

// File: rtl/dual_port_ram_pkg.sv
// Shared types and default sizes for the dual-port RAM core and its clear sequencer.
package dual_port_ram_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

endpackage

// File: rtl/dual_port_ram_init_seq.sv
// Power-up clear sequencer: walks every word address once, zeroing it, then
// parks in READY with init_done held high until the next reset.
module dual_port_ram_init_seq
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_ptr,
    output logic                  o_ready,
    output logic                  o_init_done
);

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    ram_state_t            r_state;
    ram_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic                  r_init_done;
    logic                  w_init_done_nxt;
    logic                  w_clr_we;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= CLEAR;
            r_ptr       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_init_done_nxt = r_init_done;
        w_clr_we        = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clr_we  = 1'b1;
                w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
                // init_done rises on the same edge that writes the last word
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt     = READY;
                    w_init_done_nxt = 1'b1;
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign o_clr_we    = w_clr_we;
    assign o_clr_ptr   = r_ptr;
    assign o_ready     = (r_state == READY);
    assign o_init_done = r_init_done;

endmodule

// File: rtl/dual_port_ram_core.sv
// True dual-port, read-first RAM with power-up clear sweep and A/B write collision flag.
// Optional macro DUAL_PORT_RAM_OUT_REG_EN adds one output register per port (latency 2).
module dual_port_ram_core
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  init_done,
    output logic                  collision
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_ptr;
    logic                  w_ready;
    logic                  w_init_done;

    dual_port_ram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_clr_we    (w_clr_we),
        .o_clr_ptr   (w_clr_ptr),
        .o_ready     (w_ready),
        .o_init_done (w_init_done)
    );

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_a_rd_en;
    logic w_b_rd_en;
    logic w_a_wr;
    logic w_b_wr;
    logic w_same_addr;
    logic w_wr_conflict;

    assign w_a_rd_en     = w_ready && a_en;
    assign w_b_rd_en     = w_ready && b_en;
    assign w_a_wr        = w_a_rd_en && a_we;
    assign w_b_wr        = w_b_rd_en && b_we;
    assign w_same_addr   = (a_addr == b_addr);
    assign w_wr_conflict = w_a_wr && w_b_wr && w_same_addr;

    // Array has no reset; only the sweep zeroes it. Port A wins a same-address write.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_ptr] <= '0;
        end else begin
            if (w_b_wr && !w_wr_conflict) begin
                r_mem[b_addr] <= b_wdata;
            end
            if (w_a_wr) begin
                r_mem[a_addr] <= a_wdata;
            end
        end
    end

    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;
    logic                  r_collision;

    // Reads sample the array before this edge's writes land, giving read-first data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_collision <= 1'b0;
        end else begin
            if (w_a_rd_en) begin
                r_a_rdata <= r_mem[a_addr];
            end
            if (w_b_rd_en) begin
                r_b_rdata <= r_mem[b_addr];
            end
            r_collision <= w_wr_conflict;
        end
    end

`ifdef DUAL_PORT_RAM_OUT_REG_EN
    logic                  r_a_en_d;
    logic                  r_b_en_d;
    logic [DATA_WIDTH-1:0] r_a_rdata_q;
    logic [DATA_WIDTH-1:0] r_b_rdata_q;
    logic                  r_collision_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_en_d      <= 1'b0;
            r_b_en_d      <= 1'b0;
            r_a_rdata_q   <= '0;
            r_b_rdata_q   <= '0;
            r_collision_q <= 1'b0;
        end else begin
            r_a_en_d      <= a_en;
            r_b_en_d      <= b_en;
            r_collision_q <= r_collision;
            if (r_a_en_d) begin
                r_a_rdata_q <= r_a_rdata;
            end
            if (r_b_en_d) begin
                r_b_rdata_q <= r_b_rdata;
            end
        end
    end

    assign a_rdata   = r_a_rdata_q;
    assign b_rdata   = r_b_rdata_q;
    assign collision = r_collision_q;
`else
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;
    assign collision = r_collision;
`endif

    assign init_done = w_init_done;

endmodule

// File: tb/tb_dual_port_ram_core.sv
// Scoreboard bench for dual_port_ram_core: directed vectors push expected values
// with a due cycle; a negedge monitor compares whatever is due.
`timescale 1ns/1ps
module tb_dual_port_ram_core;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int N  = 1 << AW;
`ifdef DUAL_PORT_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int K_A = 0, K_B = 1, K_C = 2, K_I = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          init_done, collision;

    dual_port_ram_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata),
        .init_done(init_done), .collision(collision)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            kind;
        logic [DW-1:0] exp;
        int            due;
        string         name;
    } chk_t;
    chk_t q[$];

    task automatic expect_at(input int kind, input logic [DW-1:0] exp, input int due, input string name);
        chk_t c;
        c.kind = kind; c.exp = exp; c.due = due; c.name = name;
        q.push_back(c);
    endtask

    always @(negedge clk) begin
        logic [DW-1:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due == cyc) begin
                case (q[i].kind)
                    K_A:     act = a_rdata;
                    K_B:     act = b_rdata;
                    K_C:     act = {{(DW-1){1'b0}}, collision};
                    default: act = {{(DW-1){1'b0}}, init_done};
                endcase
                n_total++;
                if (act === q[i].exp) n_pass++;
                else $display("FAIL %s: got %h, expected %h (cycle %0d)", q[i].name, act, q[i].exp, cyc);
                q.delete(i);
            end else if (q[i].due < cyc) begin
                n_total++;
                $display("FAIL %s: check missed its cycle %0d", q[i].name, q[i].due);
                q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic ae, input logic awe, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic be, input logic bwe, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_en = ae; a_we = awe; a_addr = aa; a_wdata = ad;
        b_en = be; b_we = bwe; b_addr = ba; b_wdata = bd;
        tick();
        a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0;
    endtask

    task automatic expect_reset_outputs(input string tag);
        expect_at(K_A, '0, cyc, {tag, "_a_rdata"});
        expect_at(K_B, '0, cyc, {tag, "_b_rdata"});
        expect_at(K_C, '0, cyc, {tag, "_collision"});
        expect_at(K_I, '0, cyc, {tag, "_init_done"});
    endtask

    // Called right after rst falls; runs the full sweep and pokes the ports while clearing.
    task automatic do_sweep(input string tag);
        int c0;
        c0 = cyc;
        expect_at(K_I, 32'd0, c0 + N - 1, {tag, "_init_low_before_N"});
        expect_at(K_I, 32'd1, c0 + N,     {tag, "_init_high_at_N"});
        for (int k = 0; k < N; k++) begin
            if (k == N - 40) begin
                expect_at(K_A, '0, cyc + LAT, {tag, "_clear_a_rdata_held"});
                expect_at(K_B, '0, cyc + LAT, {tag, "_clear_b_rdata_held"});
                op(1'b1, 1'b1, 8'h02, 32'hBAD0BAD0, 1'b1, 1'b0, 8'h10, '0);
            end else if (k == N - 30) begin
                expect_at(K_C, '0, cyc + LAT, {tag, "_clear_no_collision"});
                op(1'b1, 1'b1, 8'h20, 32'hBAD1BAD1, 1'b1, 1'b1, 8'h20, 32'hBAD2BAD2);
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        tick();
        expect_reset_outputs("reset");
        tick(); tick();
        rst = 1'b0;
        do_sweep("sweep1");

        // Every word reads back zero, including the one written during CLEAR.
        for (int i = 0; i < N; i++) begin
            expect_at(K_A, '0, cyc + LAT, "clear_read_a");
            expect_at(K_B, '0, cyc + LAT, "clear_read_b");
            op(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(N - 1 - i), '0);
        end

        expect_at(K_A, 32'h0, cyc + LAT, "wr10_old_data");
        op(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        expect_at(K_B, 32'hDEADBEEF, cyc + LAT, "b_read_10");
        op(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h10, '0);

        expect_at(K_C, 32'd1, cyc + LAT,     "collision_pulse");
        expect_at(K_C, 32'd0, cyc + LAT + 1, "collision_one_cycle");
        expect_at(K_A, 32'h0, cyc + LAT,     "coll_a_old");
        expect_at(K_B, 32'h0, cyc + LAT,     "coll_b_old");
        op(1'b1, 1'b1, 8'h20, 32'h11111111, 1'b1, 1'b1, 8'h20, 32'h22222222);
        expect_at(K_B, 32'h11111111, cyc + LAT, "coll_a_wins");
        op(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h20, '0);

        expect_at(K_C, 32'd0, cyc + LAT, "diff_addr_no_collision");
        op(1'b1, 1'b1, 8'h30, 32'h33333333, 1'b1, 1'b1, 8'h31, 32'h44444444);
        expect_at(K_A, 32'h44444444, cyc + LAT, "diff_addr_b_stored");
        expect_at(K_B, 32'h33333333, cyc + LAT, "diff_addr_a_stored");
        op(1'b1, 1'b0, 8'h31, '0, 1'b1, 1'b0, 8'h30, '0);

        op(1'b1, 1'b1, 8'h05, 32'hA5A5A5A5, 1'b0, 1'b0, '0, '0);
        expect_at(K_B, 32'hA5A5A5A5, cyc + LAT, "rf_b_old");
        expect_at(K_A, 32'hA5A5A5A5, cyc + LAT, "rf_a_old");
        op(1'b1, 1'b1, 8'h05, 32'h5A5A5A5A, 1'b1, 1'b0, 8'h05, '0);
        expect_at(K_B, 32'h5A5A5A5A, cyc + LAT, "rf_b_new");
        op(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h05, '0);

        op(1'b1, 1'b1, 8'h01, 32'h01010101, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) expect_at(K_A, 32'h01010101, cyc + LAT + k, "hold_a_rdata");
        op(1'b1, 1'b0, 8'h01, '0, 1'b0, 1'b0, '0, '0);
        tick(); tick(); tick(); tick();

        // Reset from READY must clear outputs at once, then mid-sweep reset at ptr=7.
        rst = 1'b1;
        expect_reset_outputs("rst_ready");
        tick();
        rst = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        expect_at(K_I, '0, cyc, "rst_midsweep_init");
        tick();
        rst = 1'b0;
        do_sweep("sweep2");

        expect_at(K_A, '0, cyc + LAT, "resweep_10");
        expect_at(K_B, '0, cyc + LAT, "resweep_20");
        op(1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, 8'h20, '0);
        expect_at(K_A, '0, cyc + LAT, "resweep_02");
        expect_at(K_B, '0, cyc + LAT, "resweep_05");
        op(1'b1, 1'b0, 8'h02, '0, 1'b1, 1'b0, 8'h05, '0);
        expect_at(K_A, '0, cyc + LAT, "resweep_01");
        expect_at(K_B, '0, cyc + LAT, "resweep_31");
        op(1'b1, 1'b0, 8'h01, '0, 1'b1, 1'b0, 8'h31, '0);

        repeat (LAT + 4) tick();
        foreach (q[i]) begin
            n_total++;
            $display("FAIL %s: never checked (due cycle %0d)", q[i].name, q[i].due);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
